set_compare_seq: RTL

Multi-cycle signed set-on-condition unit for the ALU's comparison path. It accepts two N-bit two's-complement operands and a condition code through a valid/ready handshake. It scans the operands MSB-first, one bit per cycle, and stops at the first differing bit. It returns an N-bit 0/1 result (SEQ/SNE/SLT/SGT/SLE/SGE) through a second valid/ready handshake, for the writeback stage that consumes set-instruction results.

---
 rtl/set_pkg.sv | 40 ++++
 rtl/bit_cmp_cell.sv | 12 +
 rtl/set_compare_seq.sv | 113 +++++++++++
 3 files changed

// File: rtl/set_pkg.sv
// Shared definitions for the sequential signed set-on-condition unit:
// condition encodings, FSM states and the (op, eq, gt) condition decode.
package set_pkg;

  localparam int unsigned N_DEF = 32;
  localparam int unsigned IDX_W = $clog2(N_DEF);
  localparam int unsigned OP_W  = 3;

  localparam logic [OP_W-1:0] OP_SEQ = 3'd0;
  localparam logic [OP_W-1:0] OP_SNE = 3'd1;
  localparam logic [OP_W-1:0] OP_SLT = 3'd2;
  localparam logic [OP_W-1:0] OP_SGT = 3'd3;
  localparam logic [OP_W-1:0] OP_SLE = 3'd4;
  localparam logic [OP_W-1:0] OP_SGE = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Reserved encodings evaluate to 0.
  function automatic logic cond_eval(input logic [OP_W-1:0] op,
                                     input logic eq,
                                     input logic gt);
    logic c;
    c = 1'b0;
    case (op)
      OP_SEQ:  c = eq;
      OP_SNE:  c = ~eq;
      OP_SLT:  c = ~eq & ~gt;
      OP_SGT:  c = gt;
      OP_SLE:  c = ~gt;
      OP_SGE:  c = gt | eq;
      default: c = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/bit_cmp_cell.sv
// Single-bit comparator cell: flags a mismatch and whether a's bit is the larger.
module bit_cmp_cell (
  input  logic a,
  input  logic b,
  output logic differ,
  output logic a_gt
);

  assign differ = a ^ b;
  assign a_gt   = a & ~b;

endmodule

// File: rtl/set_compare_seq.sv
// Multi-cycle signed set-on-condition: MSB-first bit scan that stops at the
// first differing bit, returns {N-1 zeros, cond} over a valid/ready handshake.
module set_compare_seq
  import set_pkg::*;
#(
  parameter int unsigned N = N_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N-1:0]    a,
  input  logic [N-1:0]    b,
  input  logic [OP_W-1:0] op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N-1:0]    res,
  output logic            busy
);

  localparam int unsigned IW = $clog2(N);
  localparam logic [IW-1:0] IDX_TOP = IW'(N - 1);

  state_t          state, state_nxt;
  logic [N-1:0]    a_q, b_q, res_q, res_nxt;
  logic [OP_W-1:0] op_q;
  logic [IW-1:0]   idx, idx_nxt;
  logic            capture;
  logic            decided, eq, gt;
  logic            bit_a, bit_b, differ, a_gt;

  assign bit_a = a_q[idx];
  assign bit_b = b_q[idx];

  bit_cmp_cell u_cell (
    .a      (bit_a),
    .b      (bit_b),
    .differ (differ),
    .a_gt   (a_gt)
  );

  // Next-state, scan step and result decode.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    res_nxt   = res_q;
    capture   = 1'b0;
    decided   = 1'b0;
    eq        = 1'b0;
    gt        = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          capture   = 1'b1;
          idx_nxt   = IDX_TOP;
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (differ) begin
          decided = 1'b1;
          // At the sign bit the operand with the 0 bit is the larger one.
          gt      = (idx == IDX_TOP) ? bit_b : a_gt;
        end else if (idx == '0) begin
          decided = 1'b1;
          eq      = 1'b1;
        end else begin
          idx_nxt = idx - IW'(1);
        end
        if (decided) begin
          res_nxt   = {{(N-1){1'b0}}, cond_eval(op_q, eq, gt)};
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          res_nxt   = '0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      idx   <= IDX_TOP;
      res_q <= '0;
    end else begin
      idx   <= idx_nxt;
      res_q <= res_nxt;
      if (capture) begin
        a_q  <= a;
        b_q  <= b;
        op_q <= op;
      end
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign res       = res_q;

endmodule
